// File: rtl/sim_run_controller.sv
// sim_run_controller
// Run controller for pipelined-core simulation and FPGA bring-up. It holds the
// core in reset for a fixed number of cycles after CLEAR, then lets it run while
// counting cycles. The run ends when a core writes an odd value to the TOHOST
// mailbox word, or when the optional timeout expires. The final status stays
// frozen until the next CLEAR.
module sim_run_controller #(
  parameter int ADDR_SIZE      = 10,
  parameter int DATA_SIZE      = 32,
  parameter int NUM_PORTS      = 1,
  parameter int TOHOST_ADDR    = 1023,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic                           CLK,
  input  logic                           CLEAR,
  input  logic [NUM_PORTS-1:0]           mem_write,
  input  logic [NUM_PORTS*ADDR_SIZE-1:0] daddr,
  input  logic [NUM_PORTS*DATA_SIZE-1:0] ddata_w,
  output logic                           core_reset_n,
  output logic                           core_clear,
  output logic                           running,
  output logic                           done,
  output logic                           pass,
  output logic                           timeout,
  output logic [DATA_SIZE-2:0]           exit_code,
  output logic [31:0]                    cycle_count
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_SIZE-1:0] TOHOST       = ADDR_SIZE'(TOHOST_ADDR);
  localparam logic [31:0]          HOLD_LAST    = 32'(RESET_CYCLES - 1);
  localparam logic                 TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0]          TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]          COUNT_MAX    = 32'hFFFF_FFFF;

  state_t               state_q, state_d;
  logic [31:0]          hold_q, hold_d;
  logic [31:0]          cycle_q, cycle_d;
  logic [DATA_SIZE-2:0] exit_q, exit_d;
  logic                 reset_n_q, reset_n_d;
  logic                 clear_q;
  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;

  logic                 hit_s;
  logic [DATA_SIZE-2:0] hit_code_s;

  // Mailbox hit detection: scan from the highest port down so the lowest-index hit wins.
  always_comb begin
    hit_s      = 1'b0;
    hit_code_s = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (mem_write[i] && (daddr[i*ADDR_SIZE +: ADDR_SIZE] == TOHOST) && ddata_w[i*DATA_SIZE]) begin
        hit_s      = 1'b1;
        hit_code_s = ddata_w[i*DATA_SIZE + 1 +: DATA_SIZE - 1];
      end else begin
        hit_s      = hit_s;
        hit_code_s = hit_code_s;
      end
    end
  end

  // Next-state and next-output logic for the HOLD -> RUN -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cycle_d   = cycle_q;
    exit_d    = exit_q;
    reset_n_d = reset_n_q;
    running_d = running_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d   = ST_RUN;
          reset_n_d = 1'b1;
          running_d = 1'b1;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      ST_RUN: begin
        // The terminating cycle still counts as a RUN cycle.
        cycle_d = (cycle_q == COUNT_MAX) ? cycle_q : cycle_q + 32'd1;
        if (hit_s) begin
          state_d   = ST_DONE;
          reset_n_d = 1'b0;
          running_d = 1'b0;
          done_d    = 1'b1;
          exit_d    = hit_code_s;
          pass_d    = (hit_code_s == '0);
          timeout_d = 1'b0;
        end else if (TIMEOUT_EN && (cycle_q == TIMEOUT_LAST)) begin
          state_d   = ST_DONE;
          reset_n_d = 1'b0;
          running_d = 1'b0;
          done_d    = 1'b1;
          exit_d    = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d   = ST_HOLD;
        hold_d    = 32'd0;
        cycle_d   = 32'd0;
        exit_d    = '0;
        reset_n_d = 1'b0;
        running_d = 1'b0;
        done_d    = 1'b0;
        pass_d    = 1'b0;
        timeout_d = 1'b0;
      end
    endcase
  end

  // State and output registers; CLEAR restarts the whole sequence from HOLD.
  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      state_q   <= ST_HOLD;
      hold_q    <= 32'd0;
      cycle_q   <= 32'd0;
      exit_q    <= '0;
      reset_n_q <= 1'b0;
      clear_q   <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cycle_q   <= cycle_d;
      exit_q    <= exit_d;
      reset_n_q <= reset_n_d;
      clear_q   <= ~reset_n_d;
      running_q <= running_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
    end
  end

  assign core_reset_n = reset_n_q;
  assign core_clear   = clear_q;
  assign running      = running_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign exit_code    = exit_q;
  assign cycle_count  = cycle_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Bench for sim_run_controller: two instances (2-port with a 20-cycle timeout,
// 1-port with the timeout disabled) driven by one linear directed sequence.
// Expected run results are queued when the terminating stimulus is applied and
// compared when done rises.
module tb_sim_run_controller;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int RC = 4;

  typedef struct {
    logic [DW-2:0] exit_code;
    logic          pass;
    logic          tmo;
    logic [31:0]   count;
  } exp_t;

  exp_t sb_q[$];

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // instance A: 2 ports, timeout 20
  logic            clear_a;
  logic [1:0]      mw_a;
  logic [2*AW-1:0] da_a;
  logic [2*DW-1:0] dw_a;
  logic            rn_a, cc_a, run_a, done_a, pass_a, to_a;
  logic [DW-2:0]   ex_a;
  logic [31:0]     cnt_a;

  // instance B: 1 port, timeout disabled
  logic            clear_b;
  logic [0:0]      mw_b;
  logic [AW-1:0]   da_b;
  logic [DW-1:0]   dw_b;
  logic            rn_b, cc_b, run_b, done_b, pass_b, to_b;
  logic [DW-2:0]   ex_b;
  logic [31:0]     cnt_b;

  sim_run_controller #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .NUM_PORTS(2), .TOHOST_ADDR(1023),
                       .RESET_CYCLES(RC), .TIMEOUT_CYCLES(20)) dut_a (
    .CLK(CLK), .CLEAR(clear_a), .mem_write(mw_a), .daddr(da_a), .ddata_w(dw_a),
    .core_reset_n(rn_a), .core_clear(cc_a), .running(run_a), .done(done_a),
    .pass(pass_a), .timeout(to_a), .exit_code(ex_a), .cycle_count(cnt_a));

  sim_run_controller #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .NUM_PORTS(1), .TOHOST_ADDR(1023),
                       .RESET_CYCLES(RC), .TIMEOUT_CYCLES(0)) dut_b (
    .CLK(CLK), .CLEAR(clear_b), .mem_write(mw_b), .daddr(da_b), .ddata_w(dw_b),
    .core_reset_n(rn_b), .core_clear(cc_b), .running(run_b), .done(done_b),
    .pass(pass_b), .timeout(to_b), .exit_code(ex_b), .cycle_count(cnt_b));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic idle_a();
    mw_a = '0; da_a = '0; dw_a = '0;
  endtask

  task automatic put_a(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mw_a[port]           = 1'b1;
    da_a[port*AW +: AW]  = a;
    dw_a[port*DW +: DW]  = d;
  endtask

  // CLEAR for one cycle, check the cleared state and the full HOLD window;
  // returns in the first RUN cycle (cycle_count == 0).
  task automatic reset_a(input string tag);
    clear_a = 1'b1;
    idle_a();
    @(negedge CLK);
    clear_a = 1'b0;
    check({tag, ".rst_rn"},  rn_a,   1'b0);
    check({tag, ".rst_cc"},  cc_a,   1'b1);
    check({tag, ".rst_run"}, run_a,  1'b0);
    check({tag, ".rst_done"}, done_a, 1'b0);
    check({tag, ".rst_pass"}, pass_a, 1'b0);
    check({tag, ".rst_to"},  to_a,   1'b0);
    check({tag, ".rst_ex"},  ex_a,   31'd0);
    check({tag, ".rst_cnt"}, cnt_a,  32'd0);
    for (int k = 1; k < RC; k++) begin
      @(negedge CLK);
      check($sformatf("%s.hold%0d_rn", tag, k), rn_a, 1'b0);
      check($sformatf("%s.hold%0d_run", tag, k), run_a, 1'b0);
    end
    @(negedge CLK);
    check({tag, ".run_rn"},  rn_a,  1'b1);
    check({tag, ".run_cc"},  cc_a,  1'b0);
    check({tag, ".run_run"}, run_a, 1'b1);
    check({tag, ".run_cnt"}, cnt_a, 32'd0);
  endtask

  // Wait (bounded) for done on instance A, then compare against the scoreboard.
  task automatic wait_done_a(input string tag, input int budget);
    exp_t e;
    int   k;
    k = 0;
    while (!done_a && k < budget) begin
      @(negedge CLK);
      k++;
    end
    check({tag, ".done"}, done_a, 1'b1);
    check({tag, ".sb_nonempty"}, (sb_q.size() != 0), 1'b1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, ".exit"},  ex_a,   e.exit_code);
      check({tag, ".pass"},  pass_a, e.pass);
      check({tag, ".tmo"},   to_a,   e.tmo);
      check({tag, ".cnt"},   cnt_a,  e.count);
      check({tag, ".rn"},    rn_a,   1'b0);
      check({tag, ".cc"},    cc_a,   1'b1);
      check({tag, ".run"},   run_a,  1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_a = 1'b0; idle_a();
    clear_b = 1'b0; mw_b = '0; da_b = '0; dw_b = '0;
    tick(2);

    // Test 1 + 2: reset sequence, then pass after 10 RUN cycles with one-cycle latency
    reset_a("t2");
    tick(9);
    check("t2.cnt9", cnt_a, 32'd9);
    check("t2.not_done", done_a, 1'b0);
    put_a(0, 10'd1023, 32'h0000_0001);
    sb_q.push_back('{exit_code: 31'd0, pass: 1'b1, tmo: 1'b0, count: 32'd10});
    @(negedge CLK);
    idle_a();
    check("t2.latency", done_a, 1'b1);
    wait_done_a("t2", 4);

    // Test 3: exit_code 5, later mailbox writes ignored
    reset_a("t3");
    tick(3);
    put_a(0, 10'd1023, 32'h0000_000B);
    sb_q.push_back('{exit_code: 31'd5, pass: 1'b0, tmo: 1'b0, count: 32'd4});
    @(negedge CLK);
    idle_a();
    wait_done_a("t3", 4);
    put_a(0, 10'd1023, 32'h0000_0001);
    put_a(1, 10'd1023, 32'h0000_0001);
    tick(3);
    idle_a();
    check("t3.sticky_exit", ex_a,   31'd5);
    check("t3.sticky_pass", pass_a, 1'b0);
    check("t3.frozen_cnt",  cnt_a,  32'd4);
    check("t3.sticky_done", done_a, 1'b1);

    // Test 4: two ports hit together, port 0 wins
    reset_a("t4");
    tick(2);
    put_a(0, 10'd1023, 32'h0000_0003);
    put_a(1, 10'd1023, 32'h0000_0001);
    sb_q.push_back('{exit_code: 31'd1, pass: 1'b0, tmo: 1'b0, count: 32'd3});
    @(negedge CLK);
    idle_a();
    wait_done_a("t4", 4);

    // Test 4b: port 0 writes TOHOST with bit0 clear (ignored), port 1 terminates
    reset_a("t4b");
    tick(1);
    put_a(0, 10'd1023, 32'h0000_0002);
    put_a(1, 10'd1023, 32'h0000_0007);
    sb_q.push_back('{exit_code: 31'd3, pass: 1'b0, tmo: 1'b0, count: 32'd2});
    @(negedge CLK);
    idle_a();
    wait_done_a("t4b", 4);

    // Test 6a: CLEAR mid-RUN restarts the sequence and the cycle count
    reset_a("t6a");
    tick(5);
    check("t6a.cnt5", cnt_a, 32'd5);
    reset_a("t6a_re");
    tick(3);
    check("t6a.cnt3", cnt_a, 32'd3);
    check("t6a.running", run_a, 1'b1);

    // Test 5: timeout after 20 RUN cycles
    reset_a("t5");
    sb_q.push_back('{exit_code: 31'd0, pass: 1'b0, tmo: 1'b1, count: 32'd20});
    wait_done_a("t5", 40);

    // Test 6b: CLEAR while in DONE; then hit on the last cycle beats timeout
    reset_a("t6b");
    tick(19);
    check("t5b.cnt19", cnt_a, 32'd19);
    check("t5b.not_done", done_a, 1'b0);
    put_a(0, 10'd1023, 32'h0000_0001);
    sb_q.push_back('{exit_code: 31'd0, pass: 1'b1, tmo: 1'b0, count: 32'd20});
    @(negedge CLK);
    idle_a();
    wait_done_a("t5b", 4);

    // Test 7: instance B, non-terminating writes and no timeout
    clear_b = 1'b1;
    @(negedge CLK);
    clear_b = 1'b0;
    check("t7.rst_rn",  rn_b,  1'b0);
    check("t7.rst_cnt", cnt_b, 32'd0);
    tick(RC);
    check("t7.run_rn",  rn_b,  1'b1);
    check("t7.running", run_b, 1'b1);
    mw_b = 1'b1; da_b = 10'd1022; dw_b = 32'h0000_0001;
    @(negedge CLK);
    mw_b = 1'b1; da_b = 10'd1023; dw_b = 32'h0000_0002;
    @(negedge CLK);
    mw_b = 1'b0; da_b = 10'd1023; dw_b = 32'h0000_0001;
    @(negedge CLK);
    mw_b = '0; da_b = '0; dw_b = '0;
    tick(600);
    check("t7.not_done", done_b, 1'b0);
    check("t7.no_tmo",   to_b,   1'b0);
    check("t7.running2", run_b,  1'b1);
    check("t7.rn",       rn_b,   1'b1);
    check("t7.cnt",      cnt_b,  32'd603);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
